// File: rtl/hazard_pkg.sv
// hazard_pkg: shared widths, forward-select codes and the shadow-stage record
package hazard_pkg;
    localparam int REG_W = 4;
    localparam int CNT_W = 16;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;
    localparam logic [REG_W-1:0] REG_PC = 4'd15;
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             load;
    } shadow_t;
endpackage

// File: rtl/hazard_forwarding_unit_if.sv
// hazard_forwarding_unit_if: ID-stage hazard inputs and pipeline control outputs
interface hazard_forwarding_unit_if;
    logic                            id_valid;
    logic [hazard_pkg::REG_W-1:0]    id_ra;
    logic [hazard_pkg::REG_W-1:0]    id_rb;
    logic [hazard_pkg::REG_W-1:0]    id_rd;
    logic                            id_use_ra;
    logic                            id_use_rb;
    logic                            id_use_rd;
    logic [hazard_pkg::REG_W-1:0]    id_dest;
    logic                            id_rf_e;
    logic                            id_load;
    logic                            branch_taken;
    logic                            enable_pc;
    logic                            enable_ifid;
    logic                            cu_mux_sel;
    logic                            ifid_clear;
    logic [1:0]                      s_pa;
    logic [1:0]                      s_pb;
    logic [1:0]                      s_pd;
    logic [hazard_pkg::CNT_W-1:0]    stall_count;
    modport master (
        output id_valid, id_ra, id_rb, id_rd, id_use_ra, id_use_rb, id_use_rd,
        output id_dest, id_rf_e, id_load, branch_taken,
        input  enable_pc, enable_ifid, cu_mux_sel, ifid_clear, s_pa, s_pb, s_pd, stall_count
    );
    modport slave (
        input  id_valid, id_ra, id_rb, id_rd, id_use_ra, id_use_rb, id_use_rd,
        input  id_dest, id_rf_e, id_load, branch_taken,
        output enable_pc, enable_ifid, cu_mux_sel, ifid_clear, s_pa, s_pb, s_pd, stall_count
    );
endinterface

// File: rtl/fwd_select.sv
// fwd_select: priority forward-select for one operand (index 0 = EX, 1 = MEM, 2 = WB)
module fwd_select
    import hazard_pkg::*;
(
    input  logic                       use_op,
    input  logic [REG_W-1:0]           idx,
    input  logic [2:0]                 vld,
    input  logic [2:0][REG_W-1:0]      dst,
    output logic [1:0]                 sel
);
    logic [2:0] hit;
    always_comb begin
        hit[0] = vld[0] && (dst[0] == idx);
        hit[1] = vld[1] && (dst[1] == idx);
        hit[2] = vld[2] && (dst[2] == idx);
        sel = (!use_op || idx == REG_PC) ? FWD_RF :
              hit[0] ? FWD_EX :
              hit[1] ? FWD_MEM :
              hit[2] ? FWD_WB : FWD_RF;
    end
endmodule

// File: rtl/hazard_forwarding_unit.sv
// hazard_forwarding_unit: shadow EX/MEM/WB tracking, operand forwarding, load-use stall and branch flush
module hazard_forwarding_unit
    import hazard_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    hazard_forwarding_unit_if.slave   bus
);
    shadow_t          ex, mem, wb;
    logic             stall, match_ex, unused_load;
    logic [CNT_W-1:0] cnt;
    function automatic logic src_hit(input logic u, input logic [REG_W-1:0] idx, input logic [REG_W-1:0] d);
        return u && (idx != REG_PC) && (idx == d);
    endfunction
    always_comb begin
        match_ex = src_hit(bus.id_use_ra, bus.id_ra, ex.dest) |
                   src_hit(bus.id_use_rb, bus.id_rb, ex.dest) |
                   src_hit(bus.id_use_rd, bus.id_rd, ex.dest);
        stall = ex.valid & ex.load & match_ex;
        bus.enable_pc = ~stall;
        bus.enable_ifid = ~stall;
        bus.cu_mux_sel = stall;
        bus.ifid_clear = ~stall & bus.branch_taken & bus.id_valid & reset;
        bus.stall_count = cnt;
    end
    assign unused_load = wb.load;
    // A stalled instruction stays in ID, so a bubble (valid = 0) enters EX
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex  <= '0;
            mem <= '0;
            wb  <= '0;
            cnt <= '0;
        end else begin
            wb  <= mem;
            mem <= ex;
            ex  <= {bus.id_valid & bus.id_rf_e & (bus.id_dest != REG_PC) & ~stall, bus.id_dest, bus.id_load};
            if (stall && cnt != '1) cnt <= cnt + 1'b1;
        end
    end
    fwd_select u_pa (
        .use_op (bus.id_use_ra),
        .idx    (bus.id_ra),
        .vld    ({wb.valid, mem.valid, ex.valid}),
        .dst    ({wb.dest, mem.dest, ex.dest}),
        .sel    (bus.s_pa)
    );
    fwd_select u_pb (
        .use_op (bus.id_use_rb),
        .idx    (bus.id_rb),
        .vld    ({wb.valid, mem.valid, ex.valid}),
        .dst    ({wb.dest, mem.dest, ex.dest}),
        .sel    (bus.s_pb)
    );
    fwd_select u_pd (
        .use_op (bus.id_use_rd),
        .idx    (bus.id_rd),
        .vld    ({wb.valid, mem.valid, ex.valid}),
        .dst    ({wb.dest, mem.dest, ex.dest}),
        .sel    (bus.s_pd)
    );
endmodule

// File: doc/hazard_forwarding_unit.md
# hazard_forwarding_unit

Pipeline hazard controller for the five-stage ARM-subset pipeline. It tracks the destination registers of the instructions in flight in EX, MEM and WB using its own shadow pipeline. From that state it drives the PA/PB/PD forwarding-mux selects, detects load-use hazards, and sequences stalls through the PC enable, the IF/ID enable and the control-unit NOP mux. It also squashes the fetched instruction when the condition handler resolves a taken branch in ID.

## Interface
- `REG_W`, 4, register index width.
- `CNT_W`, 16, stall-counter width.

Ports:
- `clk` in 1: pipeline clock, rising-edge.
- `reset` in 1: asynchronous, active-low.
- `id_valid` in 1: ID holds a real (non-NOP) instruction.
- `id_ra`, `id_rb`, `id_rd` in `REG_W`: source indexes I3–I0, I19–I16, I15–I12 (the PD read port).
- `id_use_ra`, `id_use_rb`, `id_use_rd` in 1: the corresponding operand is actually read.
- `id_dest` in `REG_W`: destination after the I15–I12/BL mux (R14 on BL).
- `id_rf_e`, `id_load` in 1: ID instruction writes the RF / is a load.
- `branch_taken` in 1: condition handler resolved a taken B/BL in ID.
- `enable_pc`, `enable_ifid` out 1: register enables, 0 = hold.
- `cu_mux_sel` out 1: 1 = inject NOP control word into ID/EX.
- `ifid_clear` out 1: 1 = IF/ID loads zero (NOP) at next edge.
- `s_pa`, `s_pb`, `s_pd` out 2: forward select, 00 RF, 01 EX, 10 MEM, 11 WB.
- `stall_count` out `CNT_W`: load-use stall cycles since reset.

## Operation
- Shadow stages `ex`, `mem` and `wb` each hold `{valid, dest, load}`. `valid` means the instruction writes the RF.
- At each `posedge clk`, the shadow stages advance:
  - `wb <= mem`
  - `mem <= ex`
  - `ex <= {id_valid & id_rf_e & (id_dest != 15) & ~stall, id_dest, id_load}`
- `stall` is defined as `ex.valid & ex.load & match_ex`.
  - `match_ex` is true when any used source (`id_use_x`) equals `ex.dest` and that source is not 15.
- Forward select per operand, in priority order:
  1. Operand unused, or index 15 (PC is read from the RF only) → 00.
  2. `ex.valid` and `ex.dest` equal to the index → 01.
  3. Else `mem` matches → 10.
  4. Else `wb` matches → 11.
  5. Else → 00.
- While `stall` is high:
  - `enable_pc = 0`, `enable_ifid = 0`, `cu_mux_sel = 1`, `ifid_clear = 0`.
  - Forward selects are don't-care, but are still computed by the rule above.
- Otherwise:
  - `enable_pc = 1`, `enable_ifid = 1`, `cu_mux_sel = 0`.
  - `ifid_clear = branch_taken & id_valid`.
- Stall and branch in the same cycle: the stall wins and the branch is not acted on. It is re-evaluated next cycle, when the instruction leaves the stall.
- `stall_count` increments on each clock edge where `stall` is high, and saturates at all-ones.
- Writes to R15 are never tracked. An instruction with `id_rf_e = 0` is never a forwarding source.

## Timing
- All outputs are combinational from the shadow registers plus the current ID inputs. Zero-cycle decision latency.
- A load-use stall lasts exactly one cycle. In the next cycle the load sits in MEM, and the dependent operand selects 10.
- A branch flush lasts one cycle per taken branch.
- Reset (`reset = 0`), asynchronous:
  - All shadow `valid` bits clear and `stall_count` goes to 0.
  - Outputs become `enable_pc = 1`, `enable_ifid = 1`, `cu_mux_sel = 0`, selects 00.
  - `ifid_clear` follows its rule with `id_valid` forced to 0, so it is 0.
- Reset asserted mid-stall cancels the stall immediately. No bubble is left pending.
- Release of reset: the first rising edge after release loads `ex` normally.

## Structure
- Package `hazard_pkg` holds:
  - `FWD_RF = 2'b00`, `FWD_EX = 2'b01`, `FWD_MEM = 2'b10`, `FWD_WB = 2'b11`.
  - `REG_PC = 4'd15`.
  - Struct/typedef `shadow_t {valid, dest, load}`.
- Sub-module `fwd_select` (priority compare for one operand), instantiated three times for PA, PB and PD.
- The top level holds the shadow pipeline, the stall/flush logic and the counter.

## Test plan
- **Reset:** `reset = 0` with random ID inputs → enables 1, `cu_mux_sel = 0`, `ifid_clear = 0`, all selects 00, `stall_count = 0`.
- **EX then MEM forwarding:** ADD writing R1 passes ID; next cycle ID reads `ra = 1` → `s_pa = 01`; one cycle later, with an unrelated instruction between, → `s_pa = 10`; one more cycle → `11`.
- **Priority:** two consecutive writes to R2, then `rb = 2` in ID → `s_pb = 01` (EX beats MEM).
- **Load-use:** LDR R3 then STR reading `rd = 3` → one cycle of `enable_pc = 0`, `enable_ifid = 0`, `cu_mux_sel = 1`, `stall_count = 1`; the following cycle `s_pd = 10` and enables return to 1.
- **Exclusions:**
  - A source index of 15 while R15 is the destination in EX → 00.
  - A destination with `id_rf_e = 0` → never forwarded.
- **Branch:**
  - `branch_taken = 1` with no hazard → `ifid_clear = 1` for one cycle.
  - `branch_taken = 1` during a load-use stall → `ifid_clear = 0`, then 1 next cycle.
  - Reset pulsed during a stall → stall drops in the same cycle.
